// File: rtl/char_pixel_gen_if.sv
// Character-cell handshake bundle between the text fetch logic (master)
// and char_pixel_gen (slave).
//
// Handshake: a cell transfers on a rising clk edge where char_valid and
// char_ready are both 1. While char_valid is 1 the master holds char_code
// and glyph_row stable. char_ready depends only on registered state inside
// the slave, never combinationally on char_valid.
interface char_pixel_gen_if;
  logic       char_valid;
  logic       char_ready;
  logic [7:0] char_code;
  logic [2:0] glyph_row;

  modport master (
    output char_valid,
    output char_code,
    output glyph_row,
    input  char_ready
  );

  modport slave (
    input  char_valid,
    input  char_code,
    input  glyph_row,
    output char_ready
  );
endinterface

// File: rtl/char_pixel_gen.sv
// char_pixel_gen: turns one character cell (code + scanline) into a serial
// pixel stream for a VGA-style pixel tick. A one-entry pending register
// holds the next cell and drives the character ROM address; a shifter
// emits 5 glyph columns plus GAP_COLS background columns, each held for
// SCALE pixel ticks.
//
// Optional feature: define CHAR_INVERT_EN to invert every pixel (glyph and
// gap) of a cell whose char_code[7] was set when the cell was accepted.
// Without the macro char_code[7] is ignored and no storage exists for it.
//
// dbg_active exposes the shifter state (1 = ACTIVE, 0 = EMPTY).
module char_pixel_gen #(
  parameter int SCALE    = 1,
  parameter int GAP_COLS = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  char_pixel_gen_if.slave     cbus,
  output logic [6:0]          rom_addr,
  input  logic [34:0]         rom_data,
  input  logic                pixel_en,
  output logic                pixel_out,
  output logic                cell_done,
  output logic                underrun,
  output logic                dbg_active
);

  localparam logic [2:0] LAST_COL   = 3'(4 + GAP_COLS);
  localparam logic [1:0] LAST_SCALE = 2'(SCALE - 1);

  typedef enum logic {
    EMPTY  = 1'b0,
    ACTIVE = 1'b1
  } sh_state_t;

  // Pending register
  logic       pend_full;
  logic [6:0] pend_code;
  logic [2:0] pend_row;

  // Shifter
  sh_state_t  state;
  logic [4:0] sh_bits;
  logic [2:0] col_cnt;
  logic [1:0] scale_cnt;

  logic       accept;
  logic       last_pix;
  logic       transfer;
  logic [4:0] row_bits;
  logic [7:0] col_vec;
  logic       cur_bit;
  logic       pix_val;

`ifdef CHAR_INVERT_EN
  logic pend_attr;
  logic sh_attr;
`else
  logic unused_attr;
  assign unused_attr = cbus.char_code[7];
`endif

  assign cbus.char_ready = ~pend_full;
  assign accept          = cbus.char_valid & ~pend_full;
  assign rom_addr        = pend_code;
  assign dbg_active      = (state == ACTIVE);

  // Final pixel of the current cell is emitted on this edge.
  assign last_pix = (state == ACTIVE) && pixel_en &&
                    (col_cnt == LAST_COL) && (scale_cnt == LAST_SCALE);

  // Pending moves into the shifter when the shifter is idle or finishing.
  assign transfer = pend_full && ((state == EMPTY) || last_pix);

  // Select the pending scanline out of the ROM bitmap; row 7 is blank.
  always_comb begin
    row_bits = '0;
    for (int r = 0; r < 7; r++) begin
      if (pend_row == 3'(r)) begin
        for (int c = 0; c < 5; c++) begin
          row_bits[c] = rom_data[34 - (5 * r + c)];
        end
      end
    end
  end

  // Current column pixel; columns 5..7 read the zero padding (gap columns).
  always_comb begin
    col_vec = {3'b000, sh_bits};
    cur_bit = col_vec[col_cnt];
`ifdef CHAR_INVERT_EN
    pix_val = cur_bit ^ sh_attr;
`else
    pix_val = cur_bit;
`endif
  end

  // Pending register: capture on handshake, empty on transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_full <= 1'b0;
      pend_code <= '0;
      pend_row  <= '0;
`ifdef CHAR_INVERT_EN
      pend_attr <= 1'b0;
`endif
    end else if (accept) begin
      pend_full <= 1'b1;
      pend_code <= cbus.char_code[6:0];
      pend_row  <= cbus.glyph_row;
`ifdef CHAR_INVERT_EN
      pend_attr <= cbus.char_code[7];
`endif
    end else if (transfer) begin
      pend_full <= 1'b0;
    end
  end

  // Shifter FSM with registered pixel, cell_done and underrun outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      sh_bits   <= '0;
      col_cnt   <= '0;
      scale_cnt <= '0;
      pixel_out <= 1'b0;
      cell_done <= 1'b0;
      underrun  <= 1'b0;
`ifdef CHAR_INVERT_EN
      sh_attr   <= 1'b0;
`endif
    end else begin
      cell_done <= 1'b0;
      underrun  <= 1'b0;
      if (pixel_en) begin
        if (state == ACTIVE) begin
          pixel_out <= pix_val;
          if (scale_cnt == LAST_SCALE) begin
            scale_cnt <= '0;
            if (col_cnt == LAST_COL) begin
              col_cnt   <= '0;
              cell_done <= 1'b1;
              state     <= EMPTY;
            end else begin
              col_cnt <= col_cnt + 3'd1;
            end
          end else begin
            scale_cnt <= scale_cnt + 2'd1;
          end
        end else begin
          pixel_out <= 1'b0;
          underrun  <= 1'b1;
        end
      end
      // A transfer overrides the return to EMPTY on the same edge.
      if (transfer) begin
        state     <= ACTIVE;
        sh_bits   <= row_bits;
        col_cnt   <= '0;
        scale_cnt <= '0;
`ifdef CHAR_INVERT_EN
        sh_attr   <= pend_attr;
`endif
      end
    end
  end

endmodule

// File: tb/tb_char_pixel_gen.sv
// Directed testbench for char_pixel_gen. Two instances share stimulus:
// u1 (SCALE=1, GAP_COLS=1) and u2 (SCALE=2, GAP_COLS=1). Inputs change on
// the falling edge; outputs are checked on the falling edge after the
// rising edge that produced them.
module tb_char_pixel_gen;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Shared stimulus
  logic       valid;
  logic [7:0] code;
  logic [2:0] row;
  logic       pixel_en;

  char_pixel_gen_if if1 ();
  char_pixel_gen_if if2 ();

  assign if1.char_valid = valid;
  assign if1.char_code  = code;
  assign if1.glyph_row  = row;
  assign if2.char_valid = valid;
  assign if2.char_code  = code;
  assign if2.glyph_row  = row;

  logic [6:0]  addr1, addr2;
  logic [34:0] data1, data2;
  logic        pix1, done1, und1, act1;
  logic        pix2, done2, und2, act2;

  int checks = 0;
  int errors = 0;

  // Character ROM model: row 0 first, column 0 is the MSB of each row.
  function automatic logic [34:0] rom_lookup(input logic [6:0] a);
    case (a)
      7'h41:   return 35'b01110_10001_10001_11111_10001_10001_10001;
      7'h42:   return 35'b11110_10001_10001_11110_10001_10001_11110;
      default: return 35'b0;
    endcase
  endfunction

  assign data1 = rom_lookup(addr1);
  assign data2 = rom_lookup(addr2);

  char_pixel_gen #(.SCALE(1), .GAP_COLS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .cbus(if1),
    .rom_addr(addr1), .rom_data(data1), .pixel_en(pixel_en),
    .pixel_out(pix1), .cell_done(done1), .underrun(und1), .dbg_active(act1)
  );

  char_pixel_gen #(.SCALE(2), .GAP_COLS(1)) u2 (
    .clk(clk), .rst_n(rst_n), .cbus(if2),
    .rom_addr(addr2), .rom_data(data2), .pixel_en(pixel_en),
    .pixel_out(pix2), .cell_done(done2), .underrun(und2), .dbg_active(act2)
  );

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n    = 1'b0;
    valid    = 1'b0;
    code     = 8'h00;
    row      = 3'd0;
    pixel_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Accept one cell, then let it transfer into the (empty) shifter.
  task automatic load_cell(input logic [7:0] c, input logic [2:0] r);
    valid = 1'b1;
    code  = c;
    row   = r;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; valid = 1'b0; code = 8'h00; row = 3'd0; pixel_en = 1'b0;
    @(negedge clk);
    checks++;
    if ({pix1, done1, und1, act1, addr1} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0", {pix1, done1, und1, act1, addr1});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (if1.char_ready !== 1'b1 || if2.char_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b%b expected 11", if1.char_ready, if2.char_ready);
    end
  endtask

  task automatic test_rom_addr();
    do_reset();
    valid = 1'b1; code = 8'h93; row = 3'd0;
    @(negedge clk);
    checks++;
    if (addr1 !== 7'h13) begin
      errors++;
      $display("FAIL rom_addr_low_code: got %h expected 13", addr1);
    end
    checks++;
    if (if1.char_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_when_full: got %b expected 0", if1.char_ready);
    end
    valid = 1'b0;
    @(negedge clk);
    checks++;
    if (if1.char_ready !== 1'b1 || act1 !== 1'b1) begin
      errors++;
      $display("FAIL transfer_frees_pending: got ready %b active %b expected 1 1", if1.char_ready, act1);
    end
  endtask

  task automatic test_scale1();
    logic [5:0] exp_pix;
    exp_pix = 6'b011100;
    do_reset();
    load_cell(8'h41, 3'd0);
    checks++;
    if (addr1 !== 7'h41) begin
      errors++;
      $display("FAIL scale1_rom_addr: got %h expected 41", addr1);
    end
    pixel_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (pix1 !== exp_pix[5-i] || done1 !== (i == 5) || und1 !== 1'b0) begin
        errors++;
        $display("FAIL scale1_tick%0d: got pix %b done %b und %b expected pix %b done %b und 0",
                 i, pix1, done1, und1, exp_pix[5-i], (i == 5));
      end
    end
    pixel_en = 1'b0;
    @(negedge clk);
    checks++;
    if (done1 !== 1'b0 || act1 !== 1'b0) begin
      errors++;
      $display("FAIL scale1_after: got done %b active %b expected 0 0", done1, act1);
    end
  endtask

  task automatic test_scale2();
    logic [11:0] exp_pix;
    int          dcount;
    exp_pix = 12'b001111110000;
    dcount  = 0;
    do_reset();
    load_cell(8'h41, 3'd0);
    pixel_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      dcount += int'(done2);
      checks++;
      if (pix2 !== exp_pix[11-i] || done2 !== (i == 11)) begin
        errors++;
        $display("FAIL scale2_tick%0d: got pix %b done %b expected pix %b done %b",
                 i, pix2, done2, exp_pix[11-i], (i == 11));
      end
    end
    pixel_en = 1'b0;
    @(negedge clk);
    checks++;
    if (dcount != 1 || act2 !== 1'b0) begin
      errors++;
      $display("FAIL scale2_done_count: got %0d active %b expected 1 0", dcount, act2);
    end
  endtask

  task automatic test_row1();
    logic [5:0] exp_pix;
    exp_pix = 6'b100010;
    do_reset();
    load_cell(8'h41, 3'd1);
    pixel_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (pix1 !== exp_pix[5-i] || done1 !== (i == 5)) begin
        errors++;
        $display("FAIL row1_tick%0d: got pix %b done %b expected pix %b done %b",
                 i, pix1, done1, exp_pix[5-i], (i == 5));
      end
    end
    pixel_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_hold();
    logic [5:0] exp_pix;
    exp_pix = 6'b011100;
    do_reset();
    load_cell(8'h41, 3'd0);
    pixel_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (pix1 !== exp_pix[5-i] || done1 !== (i == 5)) begin
        errors++;
        $display("FAIL hold_tick%0d: got pix %b done %b expected pix %b done %b",
                 i, pix1, done1, exp_pix[5-i], (i == 5));
      end
      if (i == 1) begin
        pixel_en = 1'b0;
        repeat (2) begin
          @(negedge clk);
          checks++;
          if (pix1 !== 1'b1 || done1 !== 1'b0 || und1 !== 1'b0) begin
            errors++;
            $display("FAIL hold_idle: got pix %b done %b und %b expected 1 0 0", pix1, done1, und1);
          end
        end
        pixel_en = 1'b1;
      end
    end
    pixel_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_underrun();
    do_reset();
    pixel_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (pix1 !== 1'b0 || und1 !== 1'b1 || if1.char_ready !== 1'b1) begin
        errors++;
        $display("FAIL underrun_tick%0d: got pix %b und %b ready %b expected 0 1 1",
                 i, pix1, und1, if1.char_ready);
      end
    end
    pixel_en = 1'b0;
    @(negedge clk);
    checks++;
    if (und1 !== 1'b0) begin
      errors++;
      $display("FAIL underrun_pulse: got %b expected 0", und1);
    end
  endtask

  task automatic test_underrun_transfer();
    logic [5:0] exp_pix;
    exp_pix = 6'b011100;
    do_reset();
    valid = 1'b1; code = 8'h41; row = 3'd0;
    @(negedge clk);
    valid = 1'b0;
    pixel_en = 1'b1;
    @(negedge clk);
    checks++;
    if (und1 !== 1'b1 || pix1 !== 1'b0 || act1 !== 1'b1) begin
      errors++;
      $display("FAIL underrun_with_transfer: got und %b pix %b active %b expected 1 0 1", und1, pix1, act1);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (pix1 !== exp_pix[5-i] || und1 !== 1'b0 || done1 !== (i == 5)) begin
        errors++;
        $display("FAIL ut_tick%0d: got pix %b und %b done %b expected pix %b und 0 done %b",
                 i, pix1, und1, done1, exp_pix[5-i], (i == 5));
      end
    end
    pixel_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp_pix;
    exp_pix = 12'b011100_111100;
    do_reset();
    valid = 1'b1; code = 8'h41; row = 3'd0;
    @(negedge clk);
    code = 8'h42;
    @(negedge clk);
    pixel_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) valid = 1'b0;
      checks++;
      if (pix1 !== exp_pix[11-i] || und1 !== 1'b0 || done1 !== (i == 5 || i == 11)) begin
        errors++;
        $display("FAIL b2b_tick%0d: got pix %b und %b done %b expected pix %b und 0 done %b",
                 i, pix1, und1, done1, exp_pix[11-i], (i == 5 || i == 11));
      end
    end
    pixel_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_blank_row();
    do_reset();
    load_cell(8'h41, 3'd7);
    pixel_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (pix1 !== 1'b0 || und1 !== 1'b0 || done1 !== (i == 5)) begin
        errors++;
        $display("FAIL blank_tick%0d: got pix %b und %b done %b expected 0 0 %b",
                 i, pix1, und1, done1, (i == 5));
      end
    end
    pixel_en = 1'b0;
    @(negedge clk);
  endtask

`ifdef CHAR_INVERT_EN
  task automatic test_invert();
    logic [5:0] exp_pix;
    exp_pix = 6'b100011;
    do_reset();
    load_cell(8'hC1, 3'd0);
    pixel_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (pix1 !== exp_pix[5-i] || done1 !== (i == 5)) begin
        errors++;
        $display("FAIL invert_tick%0d: got pix %b done %b expected pix %b done %b",
                 i, pix1, done1, exp_pix[5-i], (i == 5));
      end
    end
    pixel_en = 1'b0;
    @(negedge clk);
  endtask
`endif

  task automatic test_reset_mid();
    do_reset();
    load_cell(8'h41, 3'd0);
    pixel_en = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (pix1 !== 1'b1) begin
      errors++;
      $display("FAIL mid_third_pixel: got %b expected 1", pix1);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pix1, done1, und1, act1, addr1} !== 11'd0) begin
      errors++;
      $display("FAIL mid_async_reset: got %b expected 0", {pix1, done1, und1, act1, addr1});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (if1.char_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_ready_after: got %b expected 1", if1.char_ready);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (done1 !== 1'b0 || und1 !== 1'b1 || pix1 !== 1'b0) begin
        errors++;
        $display("FAIL mid_after_tick%0d: got done %b und %b pix %b expected 0 1 0",
                 i, done1, und1, pix1);
      end
    end
    pixel_en = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_rom_addr();
    test_scale1();
    test_scale2();
    test_row1();
    test_hold();
    test_underrun();
    test_underrun_transfer();
    test_back_to_back();
    test_blank_row();
`ifdef CHAR_INVERT_EN
    test_invert();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
